// File: rtl/pipelined_adder_mux_if.sv
// Ready/valid operand and result bundle for pipelined_adder_mux.
// The master side supplies operands and accepts results; the slave side is the adder.
interface pipelined_adder_mux_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_adder_mux.sv
// Carry-pipelined add/subtract built from mux full-adder cells: each of STAGES slices
// ripples WIDTH/STAGES bits and hands its carry to the next stage, under a global stall.
module pipelined_adder_mux #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   pipelined_adder_mux_if.slave bus
);
   localparam int SLICE = WIDTH / STAGES;

   // Mux full-adder cell: the propagate term selects between carry-in and a. Returns {carry, sum}.
   function automatic logic [1:0] mux_fa(input logic x, input logic y, input logic ci);
      logic p;
      p = x ^ y;
      return {(p ? ci : x), (p ? ~ci : ci)};
   endfunction

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;
   assign b_eff        = bus.sub ? ~bus.b : bus.b;
   assign c0           = bus.sub ? 1'b1 : bus.cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SLICE;
      localparam int HI = LO + SLICE;

      logic [SLICE-1:0] a_sl;
      logic [SLICE-1:0] b_sl;
      logic [SLICE-1:0] s_sl;
      logic [SLICE:0]   cy;
      logic [HI-1:0]    s_nx;
      logic [HI-1:0]    s_q;
      logic             v_nx;
      logic             v_q;
      logic             c_q;

      if (k == 0) begin : g_first
         assign a_sl  = bus.a[SLICE-1:0];
         assign b_sl  = b_eff[SLICE-1:0];
         assign cy[0] = c0;
         assign v_nx  = bus.in_valid;
         assign s_nx  = s_sl;
      end else begin : g_next
         assign a_sl  = g_stage[k-1].g_ops.a_q[HI-1:LO];
         assign b_sl  = g_stage[k-1].g_ops.b_q[HI-1:LO];
         assign cy[0] = g_stage[k-1].c_q;
         assign v_nx  = g_stage[k-1].v_q;
         assign s_nx  = {s_sl, g_stage[k-1].s_q};
      end

      for (genvar i = 0; i < SLICE; i++) begin : g_bit
         assign {cy[i+1], s_sl[i]} = mux_fa(a_sl[i], b_sl[i], cy[i]);
      end

      // NOTE: the data registers are reset too, so a reset leaves every stage at all-zero.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            // NOTE: non-blocking, so each stage samples its predecessor's pre-edge value.
            v_q <= v_nx;
            c_q <= cy[SLICE];
            s_q <= s_nx;
         end
      end

      // Operand slices not yet consumed travel alongside the partial sum.
      if (k < STAGES - 1) begin : g_ops
         logic [WIDTH-1:HI] a_nx;
         logic [WIDTH-1:HI] b_nx;
         logic [WIDTH-1:HI] a_q;
         logic [WIDTH-1:HI] b_q;

         if (k == 0) begin : g_src_in
            assign a_nx = bus.a[WIDTH-1:HI];
            assign b_nx = b_eff[WIDTH-1:HI];
         end else begin : g_src_prev
            assign a_nx = g_stage[k-1].g_ops.a_q[WIDTH-1:HI];
            assign b_nx = g_stage[k-1].g_ops.b_q[WIDTH-1:HI];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_nx;
               b_q <= b_nx;
            end
         end
      end else begin : g_last
         logic ovf_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= cy[SLICE] ^ cy[SLICE-1];
            end
         end
      end
   end

   assign bus.out_valid = g_stage[STAGES-1].v_q;
   assign bus.sum       = g_stage[STAGES-1].s_q;
   assign bus.cout      = g_stage[STAGES-1].c_q;
   assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
endmodule
